// File: rtl/wrr_credit_sched.sv
// wrr_credit_sched: weighted round-robin credit scheduler, one unit per ack.
// Optional grant watchdog enabled by defining WRR_GRANT_TIMEOUT_EN.
`timescale 1ns/1ps
module wrr_credit_sched #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         request,
    input  logic [CHANNELS*WIDTH-1:0]   weight,
    input  logic                        ack,
    output logic [CHANNELS-1:0]         grant,
    output logic [$clog2(CHANNELS)-1:0] grant_id,
    output logic                        round_start
`ifdef WRR_GRANT_TIMEOUT_EN
    ,
    output logic                        timeout
`endif
);

    localparam int IW = $clog2(CHANNELS);
    localparam logic [IW:0]   CH_N    = (IW+1)'(CHANNELS);
    localparam logic [IW-1:0] CH_LAST = IW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        REFILL
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    credit [CHANNELS];
    logic [IW-1:0]       ptr;

    logic [CHANNELS-1:0] elig;
    logic [CHANNELS-1:0] live_w;
    logic [CHANNELS-1:0] elig_rot;
    logic                found;
    logic [IW-1:0]       off;
    logic [IW:0]         sel_sum;
    logic [IW-1:0]       sel;

    logic                busy;
    logic [WIDTH-1:0]    cur;
    logic                req_g;
    logic                dec;
    logic                rel;
    logic                expire;
    logic [IW-1:0]       next_ptr;

    // Per-channel eligibility and nonzero-weight flags
    always_comb begin
        elig   = '0;
        live_w = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            elig[i]   = request[i] && (credit[i] != '0);
            live_w[i] = |weight[i*WIDTH +: WIDTH];
        end
    end

    // Rotate so bit 0 is the pointer position, then take the lowest set bit
    assign elig_rot = CHANNELS'({elig, elig} >> ptr);

    // Priority search over the rotated vector, nearest to the pointer wins
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
    end

    assign sel_sum = {1'b0, ptr} + {1'b0, off};
    assign sel     = (sel_sum >= CH_N) ? IW'(sel_sum - CH_N) : IW'(sel_sum);

    assign busy     = |grant;
    assign cur      = credit[grant_id];
    assign req_g    = request[grant_id];
    assign dec      = ack && req_g && (cur != '0);
    assign rel      = !req_g || (dec && (cur == WIDTH'(1)));
    assign next_ptr = (grant_id == CH_LAST) ? '0 : grant_id + 1'b1;

`ifdef WRR_GRANT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd;

    assign expire = busy && !rel && !ack && (wd == TW'(TIMEOUT - 1));
`else
    logic unused_cfg;

    assign expire     = 1'b0;
    assign unused_cfg = |32'(TIMEOUT);
`endif

    // Scheduler FSM: idle, select/serve, and credit reload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            round_start <= 1'b0;
            ptr         <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                credit[i] <= '0;
            end
`ifdef WRR_GRANT_TIMEOUT_EN
            wd          <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            round_start <= 1'b0;
`ifdef WRR_GRANT_TIMEOUT_EN
            timeout     <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (|request) begin
                        state <= SERVE;
                    end
                end
                REFILL: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        credit[i] <= weight[i*WIDTH +: WIDTH];
                    end
                    state <= SERVE;
                end
                SERVE: begin
                    if (!busy) begin
                        if (found) begin
                            grant    <= CHANNELS'(1) << sel;
                            grant_id <= sel;
                        end else if (|(request & live_w)) begin
                            state       <= REFILL;
                            round_start <= 1'b1;
                        end else if (!(|request)) begin
                            state <= IDLE;
                        end
                    end else begin
                        if (dec) begin
                            credit[grant_id] <= cur - 1'b1;
                        end
                        if (rel || expire) begin
                            grant <= '0;
                            ptr   <= next_ptr;
                        end
`ifdef WRR_GRANT_TIMEOUT_EN
                        if (expire) begin
                            credit[grant_id] <= '0;
                            timeout          <= 1'b1;
                        end
                        if (rel || expire || ack) begin
                            wd <= '0;
                        end else begin
                            wd <= wd + 1'b1;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_credit_sched.sv
// tb_wrr_credit_sched: scoreboard bench for the weighted round-robin scheduler.
// Grant episodes and refill pulses are compared against an episode-level model.
`timescale 1ns/1ps
module tb_wrr_credit_sched;

    localparam int W  = 32;
    localparam int CH = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [CH-1:0]   request = '0;
    logic [CH*W-1:0] weight = '0;
    logic            ack = 1'b0;
    logic [CH-1:0]   grant;
    logic [2:0]      grant_id;
    logic            round_start;
`ifdef WRR_GRANT_TIMEOUT_EN
    logic            timeout;
`endif

    always #5 clk = ~clk;

    wrr_credit_sched #(.WIDTH(W), .CHANNELS(CH), .TIMEOUT(16)) dut (
        .clk(clk),
        .reset(reset),
        .request(request),
        .weight(weight),
        .ack(ack),
        .grant(grant),
        .grant_id(grant_id),
        .round_start(round_start)
`ifdef WRR_GRANT_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    // kind 0 = grant episode, kind 1 = refill pulse
    typedef struct {
        int kind;
        int ch;
        int units;
        int dur;
        int gap;
    } item_t;

    item_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int wgt[CH];
    int to_cnt = 0;

    bit in_ep = 0;
    int ep_ch, ep_units, ep_dur, ep_gap;
    int gap_run = -1;

    function automatic void push_ep(int c, int u, int d, int g);
        exp_q.push_back('{kind: 0, ch: c, units: u, dur: d, gap: g});
    endfunction

    function automatic void push_rs();
        exp_q.push_back('{kind: 1, ch: 0, units: 0, dur: 0, gap: 0});
    endfunction

    function automatic void common_weights();
        for (int i = 0; i < CH; i++) wgt[i] = 3 + 2 * i;
    endfunction

    task automatic apply_weights();
        for (int i = 0; i < CH; i++) weight[i*W +: W] = W'(wgt[i]);
    endtask

    // Episode-level model: constant request, ack always high, from reset.
    function automatic void build_expect(input logic [CH-1:0] req, input int n_ep);
        int cr[CH];
        int p, made, g;
        bit first, refilled, any;
        for (int i = 0; i < CH; i++) cr[i] = 0;
        p = 0; made = 0; first = 1; refilled = 0;
        while (made < n_ep) begin
            g = -1;
            for (int k = 0; k < CH; k++) begin
                int j;
                j = (p + k) % CH;
                if (g < 0 && req[j] && cr[j] > 0) g = j;
            end
            if (g >= 0) begin
                push_ep(g, cr[g], cr[g], first ? -1 : (refilled ? 3 : 1));
                cr[g] = 0;
                p = (g + 1) % CH;
                first = 0; refilled = 0;
                made++;
            end else begin
                any = 0;
                for (int i = 0; i < CH; i++) if (req[i] && wgt[i] > 0) any = 1;
                if (!any) break;
                push_rs();
                for (int i = 0; i < CH; i++) cr[i] = wgt[i];
                refilled = 1;
            end
        end
    endfunction

    task automatic report(int kind, int c, int u, int d, int g);
        item_t e;
        bit ok;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        checks++;
        ok = (e.kind == kind);
        if (ok && kind == 0)
            ok = (e.ch == c) && (e.units == u) &&
                 (e.dur < 0 || e.dur == d) && (e.gap < 0 || e.gap == g);
        if (!ok) begin
            errors++;
            $display("FAIL scoreboard: got kind=%0d ch=%0d units=%0d dur=%0d gap=%0d, expected kind=%0d ch=%0d units=%0d dur=%0d gap=%0d",
                     kind, c, u, d, g, e.kind, e.ch, e.units, e.dur, e.gap);
        end
    endtask

    // Monitor: assemble grant episodes and refill pulses, compare in order
    always @(negedge clk) begin
        if (!reset) begin
            in_ep   = 0;
            gap_run = -1;
        end else begin
`ifdef WRR_GRANT_TIMEOUT_EN
            if (timeout) to_cnt++;
`endif
            if (grant != '0) begin
                if (!in_ep) begin
                    in_ep = 1;
                    ep_ch = int'(grant_id);
                    ep_units = 0; ep_dur = 0; ep_gap = gap_run;
                    if (exp_q.size() != 0) begin
                        checks++;
                        if (grant != (8'd1 << grant_id)) begin
                            errors++;
                            $display("FAIL onehot: grant=%b grant_id=%0d", grant, grant_id);
                        end
                    end
                end
                ep_dur++;
                if (ack && request[ep_ch]) ep_units++;
            end else if (in_ep) begin
                in_ep   = 0;
                gap_run = 1;
                report(0, ep_ch, ep_units, ep_dur, ep_gap);
            end else if (gap_run >= 0) begin
                gap_run++;
            end
            if (round_start) report(1, 0, 0, 0, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        tick();
        reset = 1'b0; ack = 1'b0; request = '0;
        tick(); tick();
        exp_q.delete();
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events pending after %0d cycles, required 0",
                     exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic wait_grant(int budget);
        int n = 0;
        while (grant == '0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (grant == '0) begin
            errors++;
            $display("FAIL grant_wait: grant=%b after %0d cycles, required nonzero", grant, n);
        end
    endtask

    // Reset is low on entry; release it and measure edges to first grant
    task automatic latency(input logic [CH-1:0] req, input int exp_ch);
        int edges = 0;
        int rs_edge = -1;
        request = req; ack = 1'b0;
        tick();
        reset = 1'b1;
        while (grant == '0 && edges < 20) begin
            tick();
            edges++;
            if (round_start && rs_edge < 0) rs_edge = edges;
        end
        checks += 3;
        if (edges != 4) begin
            errors++;
            $display("FAIL latency: first grant after %0d edges, required 4", edges);
        end
        if (int'(grant_id) != exp_ch) begin
            errors++;
            $display("FAIL first_ch: grant_id=%0d, required %0d", grant_id, exp_ch);
        end
        if (rs_edge != 2) begin
            errors++;
            $display("FAIL round_start_edge: seen after edge %0d, required 2", rs_edge);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [CH-1:0] req;
        bit seen;
        int to0;

        // 1: reset values and first-grant latency
        common_weights();
        apply_weights();
        reset = 1'b0;
        request = 8'hFF;
        tick(); tick();
        checks += 3;
        if (grant != '0) begin
            errors++; $display("FAIL rst_grant: %b, required 0", grant);
        end
        if (grant_id != '0) begin
            errors++; $display("FAIL rst_grant_id: %0d, required 0", grant_id);
        end
        if (round_start != 1'b0) begin
            errors++; $display("FAIL rst_round_start: %b, required 0", round_start);
        end
        latency(8'hFF, 0);

        // 2: single requester, repeated rounds
        hold_reset();
        common_weights(); apply_weights();
        request = 8'b0000_1000; ack = 1'b1;
        build_expect(request, 2);
        reset = 1'b1;
        wait_drain(100);

        // 3: three requesters, full round plus wrap
        hold_reset();
        request = 8'b1001_0001; ack = 1'b1;
        build_expect(request, 4);
        reset = 1'b1;
        wait_drain(200);

        // 4: request drop mid-grant keeps leftover credit
        hold_reset();
        request = 8'b0000_0010; ack = 1'b0;
        push_rs();
        push_ep(1, 2, 3, -1);
        push_ep(1, 3, 3, -1);
        reset = 1'b1;
        wait_grant(20);
        ack = 1'b1;
        tick(); tick();
        ack = 1'b0; request = '0;
        tick(); tick(); tick();
        request = 8'b0000_0010; ack = 1'b1;
        wait_drain(50);

        // 5: grant held with no ack
        hold_reset();
        request = 8'b0000_1000; ack = 1'b0;
        push_rs();
`ifdef WRR_GRANT_TIMEOUT_EN
        push_ep(3, 0, 16, -1);
        push_rs();
        push_ep(3, 9, 10, 3);
`else
        push_ep(3, 9, 29, -1);
`endif
        to0 = to_cnt;
        reset = 1'b1;
        wait_grant(20);
        repeat (20) tick();
        ack = 1'b1;
        wait_drain(100);
`ifdef WRR_GRANT_TIMEOUT_EN
        checks++;
        if (to_cnt - to0 != 1) begin
            errors++;
            $display("FAIL timeout_pulses: %0d, required 1", to_cnt - to0);
        end
`endif

        // 6: reset in the middle of a grant
        hold_reset();
        request = 8'b0001_0000; ack = 1'b1;
        reset = 1'b1;
        wait_grant(20);
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        checks += 2;
        if (grant != '0) begin
            errors++; $display("FAIL async_reset_grant: %b, required 0", grant);
        end
        if (round_start != 1'b0) begin
            errors++; $display("FAIL async_reset_rs: %b, required 0", round_start);
        end
        latency(8'b0001_0000, 4);

        // Randomized weights and request patterns
        for (int t = 0; t < 20; t++) begin
            hold_reset();
            for (int i = 0; i < CH; i++) wgt[i] = int'($urandom_range(0, 6));
            apply_weights();
            req = 8'($urandom_range(1, 255));
            request = req; ack = 1'b1;
            build_expect(req, 6);
            reset = 1'b1;
            if (exp_q.size() == 0) begin
                seen = 0;
                repeat (30) begin
                    tick();
                    if (grant != '0) seen = 1;
                end
                checks++;
                if (seen) begin
                    errors++;
                    $display("FAIL zero_weight: grant seen for req=%b, required none", req);
                end
            end else begin
                wait_drain(400);
            end
        end

        hold_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wrr_credit_sched.md
Name: wrr_credit_sched

Overview:
- Weighted round-robin credit scheduler that shares one downstream resource among CHANNELS requesters.
- Each channel receives a per-round credit budget loaded from its WIDTH-bit weight.
- A grant is held while the consumer acknowledges served units; one unit consumes one credit.
- Sits between the requesting channels and the shared datapath and sequences access to it unit by unit.

Parameters:
- WIDTH, 32, width of each weight and credit counter.
- CHANNELS, 8, number of requesters; weight bus is CHANNELS*WIDTH.
- TIMEOUT, 16, grant watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- request  input  CHANNELS  per-channel request level.
- weight  input  CHANNELS*WIDTH  per-channel credit load value; channel i occupies bits [i*WIDTH +: WIDTH].
- ack  input  1  consumer has served one unit for the current grant this cycle.
- grant  output  CHANNELS  registered, one-hot or zero.
- grant_id  output  clog2(CHANNELS)  index of the granted channel; holds its last value when grant is 0.
- round_start  output  1  one-cycle pulse when credits are reloaded.

Behaviour:
- Reset (reset=0, asynchronous): grant=0, grant_id=0, round_start=0, all credits=0, pointer=0, state=IDLE.
- Eligibility: channel i is eligible when request[i]=1 and credit[i]!=0.
- Weight use: weight is sampled only in REFILL. Changes to weight mid-round take effect at the next REFILL.
- IDLE:
  - request!=0 -> SERVE.
  - Otherwise stay in IDLE. Credits are retained.
- SERVE with grant=0:
  - If any channel is eligible, select the first eligible channel searching from pointer upward with wrap. grant and grant_id load at the next edge.
  - Otherwise, if (request & nonzero-weight)!=0 -> REFILL.
  - Otherwise, if request=0 -> IDLE.
  - Otherwise (only zero-weight requesters): stay in SERVE, grant=0, no refill.
- REFILL: credit[i]=weight[i] for all i. round_start=1 for exactly that cycle. Pointer is unchanged. -> SERVE.
- SERVE with grant on channel g:
  - ack=1 and request[g]=1: credit[g] decrements.
  - ack=0: grant held, credit unchanged.
  - Release condition: the decrement brings credit[g] to 0, or request[g]=0.
  - On release: grant clears at the next edge, pointer = (g+1) mod CHANNELS, and the leftover credit stays with g.
  - The cycle after a release is a selection cycle, so consecutive grants are separated by exactly one grant=0 cycle.
- ack while grant=0 is ignored.
- Latency from reset with request asserted before edge N (credits all 0):
  - Edge N: IDLE -> SERVE.
  - Edge N+1: -> REFILL.
  - Edge N+2: credits loaded, round_start seen high in the cycle before this edge.
  - grant high after edge N+3.
- Arithmetic: credit counters are WIDTH bits and never underflow; a decrement happens only when the credit is nonzero.
- Zero-weight channel: never granted.
- Pointer wrap: pointer goes from CHANNELS-1 back to 0.
- Reset mid-grant: grant drops immediately (asynchronously) and all state clears.

Optional Feature:
- Macro: WRR_GRANT_TIMEOUT_EN.
- Defined:
  - A watchdog counts consecutive granted cycles with ack=0.
  - When the count reaches TIMEOUT, credit[g] is zeroed, grant clears at the next edge, and pointer advances as on a normal release.
  - An extra output port timeout (1 bit) pulses for one cycle at the revocation. timeout resets to 0.
  - The counter clears on any ack or on release.
- Undefined: no counter, no timeout port; a grant is held indefinitely while ack=0.

Test Plan:
Common setup: weight[i] = 3+2i, i.e. ch0=3, ch1=5, ch3=9, ch4=11, ch7=17.
1. Assert reset=0 with request=8'hFF -> grant=0, grant_id=0, round_start=0. Release reset -> first grant appears exactly 4 edges later, on ch0.
2. request=8'b00001000, ack held 1 -> grant=8'b00001000 for 9 cycles, then 1 cycle grant=0 plus a round_start pulse and REFILL, then grant ch3 again for 9 cycles.
3. request=8'b10010001, ack=1 -> grant sequence is ch0 x3, gap, ch4 x11, gap, ch7 x17, then a round_start pulse and ch0 x3 again.
4. Grant on ch1 (weight 5): give 2 acks, then drop request[1] -> grant clears next edge. Reassert request[1] alone -> ch1 regranted for exactly 3 acks, with no refill between.
5. Grant on ch3 with ack=0 for 20 cycles -> grant held, credit unchanged. With WRR_GRANT_TIMEOUT_EN: revoked after 16 cycles, timeout pulses once, next eligible channel selected.
6. Assert reset=0 in the middle of a ch4 grant -> grant=0 immediately and all credits 0. After release the scheduler re-enters via IDLE -> SERVE -> REFILL.
